newton_div_param: RTL and testbench

//  Parametrised Newton-Raphson mantissa divider for the pipelined FPU (single and double precision).

---
 rtl/newton_div_param.sv | 184 ++++++++++++++++++
 tb/tb_newton_div_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/newton_div_param.sv
// Newton-Raphson mantissa divider for the FPU EX stage.
// Seeds 1/b from a 16-entry table, refines ITER times with x <= x*(2-b*x),
// then forms q = a*x with a guard/sticky tail. Start/done handshake,
// synchronous cancel and a one-cycle divide-by-zero shortcut.
//
// Fixed-point view: a and b are read as 0.MW fractions (so b lies in [0.5,1)),
// x and p carry 2.(XW-2) style integer/fraction splits, bx is 1.(XW-1).
// XW is MW+8: with MW+2 the last-bit truncation of x alone would cost up to
// 64 quotient LSBs, far outside the 8-LSB error budget.
module newton_div_param #(
  parameter int MW   = 24,
  parameter int XW   = MW + 8,
  parameter int ITER = 3,
  parameter int SW   = $clog2(2*ITER+3)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          cancel,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [MW+7:0] q,
  output logic          done,
  output logic          dz,
  output logic          busy,
  output logic          stall,
  output logic [SW-1:0] step
);

  localparam int PW  = MW + XW;   // a*x and b*x product width
  localparam int XW2 = 2 * XW;    // x*(2-bx) product width

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BX   = 3'd1;
  localparam logic [2:0] ST_XU   = 3'd2;
  localparam logic [2:0] ST_MUL  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // Step value seen in the last XU cycle; after it the reciprocal is final.
  localparam logic [SW-1:0] STEP_LAST_XU = SW'(2*ITER);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] step_q,  step_d;
  logic [MW-1:0] a_q,     a_d;
  logic [MW-1:0] b_q,     b_d;
  logic [XW-1:0] x_q,     x_d;
  logic [XW-1:0] bx_q,    bx_d;
  logic [PW-1:0] p_q,     p_d;
  logic [MW+7:0] q_q,     q_d;
  logic          done_q,  done_d;
  logic          dz_q,    dz_d;
  logic [XW-1:0] two_minus_bx;

  // Seed table: fraction part of 2/(1+(i+0.5)/16), i = top 4 fraction bits of b.
  function automatic logic [7:0] seed_rom(input logic [3:0] idx);
    case (idx)
      4'h0: seed_rom = 8'hF0;
      4'h1: seed_rom = 8'hD4;
      4'h2: seed_rom = 8'hBB;
      4'h3: seed_rom = 8'hA4;
      4'h4: seed_rom = 8'h90;
      4'h5: seed_rom = 8'h7D;
      4'h6: seed_rom = 8'h6C;
      4'h7: seed_rom = 8'h5D;
      4'h8: seed_rom = 8'h4E;
      4'h9: seed_rom = 8'h41;
      4'hA: seed_rom = 8'h35;
      4'hB: seed_rom = 8'h2A;
      4'hC: seed_rom = 8'h1F;
      4'hD: seed_rom = 8'h16;
      4'hE: seed_rom = 8'h0D;
      4'hF: seed_rom = 8'h04;
    endcase
  endfunction

  // Next-state and datapath: one multiply per cycle, selected by state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    step_d       = step_q;
    a_d          = a_q;
    b_d          = b_q;
    x_d          = x_q;
    bx_d         = bx_q;
    p_d          = p_q;
    q_d          = q_q;
    done_d       = 1'b0;
    dz_d         = dz_q;
    // bx is 1.(XW-1), so its XW-bit two's complement is exactly 2-bx.
    two_minus_bx = ~bx_q + XW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (b[MW-1]) begin
            a_d     = a;
            b_d     = b;
            x_d     = {2'b01, seed_rom(b[MW-2 -: 4]), {(XW-10){1'b0}}};
            step_d  = SW'(1);
            state_d = ST_BX;
          end else begin
            // Unnormalised or zero divisor: answer immediately, never go busy.
            q_d    = '1;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_BX: begin
        bx_d    = XW'((PW'(b_q) * PW'(x_q)) >> (MW-1));
        step_d  = step_q + SW'(1);
        state_d = ST_XU;
      end
      ST_XU: begin
        x_d     = XW'((XW2'(x_q) * XW2'(two_minus_bx)) >> (XW-1));
        step_d  = step_q + SW'(1);
        state_d = (step_q == STEP_LAST_XU) ? ST_MUL : ST_BX;
      end
      ST_MUL: begin
        p_d     = PW'(a_q) * PW'(x_q);
        step_d  = step_q + SW'(1);
        state_d = ST_FIN;
      end
      ST_FIN: begin
        // Keep weights 2^1..2^-(MW+5) and fold the rest into a sticky LSB.
        q_d     = {p_q[PW-1:XW-7], |p_q[XW-7:0]};
        dz_d    = 1'b0;
        done_d  = 1'b1;
        step_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        step_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything in flight; results of the last op are kept.
    if (cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      step_d  = '0;
      done_d  = 1'b0;
      q_d     = q_q;
      dz_d    = dz_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the operand/reciprocal registers are reset too; they are few and it keeps outputs deterministic.
    if (!resetn) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      bx_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      bx_q    <= bx_d;
      p_q     <= p_d;
      q_q     <= q_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign q     = q_q;
  assign done  = done_q;
  assign dz    = dz_q;
  assign busy  = (state_q != ST_IDLE);
  assign stall = start | busy;
  assign step  = step_q;

endmodule

// File: tb/tb_newton_div_param.sv
// Scoreboarded bench for newton_div_param (MW=24, ITER=3).
module tb_newton_div_param;
  localparam int MW    = 24;
  localparam int ITER  = 3;
  localparam int SW    = $clog2(2*ITER+3);
  localparam int QW    = MW + 8;
  localparam int LAT   = 2*ITER + 2;
  localparam int NRAND = 3000;

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          cancel = 1'b0;
  logic [MW-1:0] a = '0;
  logic [MW-1:0] b = '0;
  logic [QW-1:0] q;
  logic          done, dz, busy, stall;
  logic [SW-1:0] step;

  newton_div_param #(.MW(MW), .ITER(ITER)) dut (
    .clock(clock), .resetn(resetn), .start(start), .cancel(cancel),
    .a(a), .b(b), .q(q), .done(done), .dz(dz), .busy(busy),
    .stall(stall), .step(step)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    int            issue;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: q/2^(MW+6) must be within 8 LSBs of the exact ratio a/b.
  function automatic bit quot_ok(input logic [MW-1:0] av, input logic [MW-1:0] bv,
                                 input logic [QW-1:0] qv, output longint ideal);
    longint num, diff;
    num   = longint'(av) << (MW+6);
    ideal = num / longint'(bv);
    diff  = longint'(qv) * longint'(bv) - num;
    return (diff <= 8 * longint'(bv)) && (diff >= -8 * longint'(bv));
  endfunction

  // Monitor: every done pops one expectation and checks timing and value.
  always @(negedge clock) begin : monitor
    exp_t   e;
    longint ideal;
    int     lat;
    bit     ok;
    if (resetn && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1'b0, 1, 0);
      end else begin
        e   = sb.pop_front();
        lat = e.b[MW-1] ? LAT + 1 : 1;
        check("latency", (cyc - e.issue) == lat, cyc - e.issue, lat);
        if (!e.b[MW-1]) begin
          check("dz_q", q == '1, q, {QW{1'b1}});
          check("dz_flag", dz == 1'b1, dz, 1);
        end else begin
          check("dz_clear", dz == 1'b0, dz, 0);
          if (e.a == '0) begin
            check("zero_q", q == '0, q, 0);
          end else begin
            ok = quot_ok(e.a, e.b, q, ideal);
            check("quotient", ok, q, ideal);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic [MW-1:0] av, input logic [MW-1:0] bv);
    exp_t e;
    a = av;
    b = bv;
    start = 1'b1;
    e.a = av;
    e.b = bv;
    e.issue = cyc;
    sb.push_back(e);
  endtask

  // Wait for the scoreboard to empty, counting busy cycles; bounded.
  task automatic drain(input int budget, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      if (busy) busy_cnt++;
      if (sb.size() == 0) return;
    end
    check("timeout", 1'b0, sb.size(), 0);
    sb.delete();
  endtask

  initial begin : stim
    int            bc;
    int            stall_bad;
    exp_t          e;
    logic [31:0]   r;
    logic [MW-1:0] ra, rb;

    repeat (3) tick();
    check("rst_q",     q == '0,     q,     0);
    check("rst_done",  done == 1'b0, done, 0);
    check("rst_dz",    dz == 1'b0,   dz,   0);
    check("rst_busy",  busy == 1'b0, busy, 0);
    check("rst_step",  step == '0,   step, 0);
    check("rst_stall", stall == 1'b0, stall, 0);
    resetn = 1'b1;
    tick();

    // 1.0 / 1.0: busy for exactly 2*ITER+2 cycles.
    issue(24'h800000, 24'h800000);
    drain(40, bc);
    check("busy_cycles", bc == LAT, bc, LAT);

    issue(24'hC00000, 24'h800000);
    drain(40, bc);
    issue(24'h800000, 24'hC00000);
    drain(40, bc);
    check("sticky_2_3", q[0] == 1'b1, q[0], 1);
    issue(24'h000000, 24'hA00000);
    drain(40, bc);
    issue(24'hFFFFFF, 24'h800000);
    drain(40, bc);
    issue(24'h800000, 24'hFFFFFF);
    drain(40, bc);

    // Unnormalised divisor: immediate answer, never busy.
    issue(24'h800000, 24'h400000);
    drain(40, bc);
    check("dz_busy", bc == 0, bc, 0);

    // Cancel at step 3: no done, q/dz keep the divide-by-zero result.
    issue(24'h800000, 24'h800000);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("cancel_step", step == SW'(3), step, 3);
    cancel = 1'b1;
    e = sb.pop_back();
    tick();
    cancel = 1'b0;
    check("cancel_busy", busy == 1'b0, busy, 0);
    check("cancel_stepz", step == '0, step, 0);
    check("cancel_q_hold", q == '1, q, {QW{1'b1}});
    check("cancel_dz_hold", dz == 1'b1, dz, 1);
    issue(24'hC00000, 24'h800000);
    drain(40, bc);

    // Cancel together with start in IDLE: nothing accepted.
    a = 24'h900000;
    b = 24'h900000;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    check("cancel_idle_busy", busy == 1'b0, busy, 0);
    repeat (12) tick();

    // Start held high: one op, then the next begins right after done.
    issue(24'h800000, 24'hA00000);
    stall_bad = 0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      tick();
      if (!stall) stall_bad++;
    end
    check("held_first_done", sb.size() == 0, sb.size(), 0);
    sb.delete();
    e.a = a;
    e.b = b;
    e.issue = cyc;
    sb.push_back(e);
    tick();
    if (!stall) stall_bad++;
    start = 1'b0;
    check("held_stall", stall_bad == 0, stall_bad, 0);
    drain(40, bc);

    // Asynchronous reset at step 5.
    issue(24'hC00000, 24'hA00000);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("reset_step", step == SW'(5), step, 5);
    resetn = 1'b0;
    #1;
    check("midrst_q",    q == '0,      q,    0);
    check("midrst_done", done == 1'b0, done, 0);
    check("midrst_dz",   dz == 1'b0,   dz,   0);
    check("midrst_busy", busy == 1'b0, busy, 0);
    check("midrst_step", step == '0,   step, 0);
    sb.delete();
    tick();
    resetn = 1'b1;
    repeat (12) tick();

    // Random operands, occasional zero dividend or unnormalised divisor.
    for (int n = 0; n < NRAND; n++) begin
      r  = $urandom;
      ra = {1'b1, r[MW-2:0]};
      if ($urandom_range(0, 15) == 0) ra = '0;
      r  = $urandom;
      rb = {1'b1, r[MW-2:0]};
      if ($urandom_range(0, 31) == 0) rb[MW-1] = 1'b0;
      issue(ra, rb);
      drain(40, bc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
